emif_master: RTL and testbench
==============================

# emif_master

EMIF SDRAM-style command initiator for the Control Board V3 bench and FPGA-to-FPGA link. It turns single-word host requests into the ACTIVE → READ/WRITE → PRECHARGE command sequence that the board's EMIF slave decoder samples at 200 MHz, and returns read data. It also generates periodic auto-refresh. It sits between a local host or test sequencer and the EMIF pins.

## Interface
Parameters:
- CMD_CYC, 4: clk cycles each command is held on the pins (≥1).
- TRCD, 4: NOP cycles between ACTIVE and READ/WRITE (≥1).
- TRP, 4: NOP cycles after PRECHARGE (≥1).
- RD_LAT, 8: cycles from first READ cycle to the emif_din sample point (≥CMD_CYC).
- TRFC, 16: NOP cycles after REFRESH (≥1).
- REF_PERIOD, 1560: clk cycles between refresh requests (≥64).

Ports:
- clk  in  1  200 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  host request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  26  [25:13] row, [12:0] column.
- req_wdata  in  16  write data.
- req_be  in  2  byte enables, [0] low byte.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_rdata  out  16  read data, valid with rsp_valid.
- emif_cke, emif_ce, emif_ras, emif_cas, emif_we  out  1 each  command pins, ce/ras/cas/we active-low.
- emif_dqm0, emif_dqm1  out  1 each  byte masks, active-high mask.
- emif_addr  out  13  multiplexed row/column address.
- emif_dout  out  16  write data to pad.
- emif_doe  out  1  pad output enable.
- emif_din  in  16  read data from pad.

## Operation
- Encodings on {ce,ras,cas,we}: DESELECT 1111, NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010 with emif_addr[10]=1 (all banks), REFRESH 0001.
- All pin outputs are registered.
- FSM states: IDLE, ACT, TRCD_W, RD, RD_WAIT, WR, PRE, TRP_W, REF, TRFC_W.
- IDLE drives DESELECT with dqm=11. req_ready=1 only in IDLE with no refresh pending.
- Handshake: a request is accepted on the edge where req_valid & req_ready. Addr, we, wdata and be are latched on that edge, and req_ready drops on the next cycle. req_valid held while req_ready=0 has no effect.
- Read path: ACT (row on addr) → TRCD_W (NOP) → RD (column on addr, dqm=~be) → RD_WAIT. emif_din is sampled on the cycle RD_LAT after the first RD cycle. rsp_rdata is registered and rsp_valid pulses on the following cycle. Then PRE → TRP_W → IDLE.
- Write path: ACT → TRCD_W → WR (column on addr, dqm=~be, emif_doe=1, emif_dout=wdata) → PRE → TRP_W → IDLE. emif_doe is 1 only during WR cycles.
- Outside RD/WR, dqm=11. During every NOP cycle, emif_addr holds its last value.
- Refresh (macro-dependent): a counter counts REF_PERIOD cycles and then sets a pending flag. The flag saturates at one; a second expiry while pending is dropped.
- In IDLE, pending refresh wins over req_valid in the same cycle. Sequence is REF → TRFC_W → IDLE, and pending clears on entry to REF.
- emif_cke=0 in reset and rises to 1 on the first clk after rst_n deassertion. It stays 1.
- Reset mid-operation: all state returns immediately to IDLE values. An in-flight request is lost and no rsp_valid is generated.

## Timing
- Reset values: req_ready=0; rsp_valid=0; rsp_rdata=0; emif_cke=0; ce=ras=cas=we=1; dqm0=dqm1=1; emif_addr=0; emif_dout=0; emif_doe=0; refresh counter=0; pending=0.
- req_ready is 1 on the second clk after reset release.
- With defaults and acceptance at cycle 0:
  - ACTIVE on cycles 1–4, NOP 5–8, READ/WRITE 9–12.
  - Write: PRECHARGE 13–16, NOP 17–20, req_ready=1 at cycle 21.
  - Read: emif_din sampled at cycle 17, rsp_valid at 18, PRECHARGE 18–21, NOP 22–25, req_ready=1 at 26.
  - General read sample point: 1+CMD_CYC+TRCD+RD_LAT.
- Refresh with defaults: REFRESH held 4 cycles, then 16 NOP cycles, then IDLE.
- The refresh counter runs continuously, including during transactions.

## Configuration
- EMIF_MASTER_REFRESH_EN defined: the refresh counter, pending flag and the REF/TRFC_W states are compiled in.
- Undefined: no counter, REFRESH is never issued, and req_ready depends only on state==IDLE.

## Test plan
- Reset then write: addr=26'h0012345, wdata=16'hA55A, be=11 → ACTIVE with addr=row 13'h0009 on cycles 1–4; WRITE with addr=13'h0345 on cycles 9–12 with doe=1, dout=A55A, dqm=00; PRECHARGE with addr[10]=1; req_ready=1 at cycle 21.
- Read with be=01, emif_din=16'h1234 at cycle 17 → READ with dqm0=0, dqm1=1; rsp_valid one cycle at 18 with rsp_rdata=1234; req_ready=1 at 26.
- Back-to-back: req_valid held high for two requests → second accepted exactly at the cycle req_ready returns; no command overlap.
- Refresh collision (macro on, REF_PERIOD=64): request raised in the same cycle pending sets → REFRESH 0001 for 4 cycles and 16 NOPs first, then the request is served; refresh repeats every 64 cycles.
- rst_n pulsed low during the READ phase → pins return to DESELECT with dqm=11 and doe=0 asynchronously; no rsp_valid; a normal read completes after release.
- Macro off, run 5000 idle cycles → no REFRESH command; req_ready constantly 1.

Source files
------------

// File: rtl/emif_master.sv
// emif_master: SDRAM-style EMIF command initiator (ACTIVE -> READ/WRITE -> PRECHARGE) with registered pins.
// Define EMIF_MASTER_REFRESH_EN to compile in the periodic auto-refresh counter, pending flag and REF/TRFC_W states.
module emif_master #(
    parameter int CMD_CYC    = 4,
    parameter int TRCD       = 4,
    parameter int TRP        = 4,
    parameter int RD_LAT     = 8,
    parameter int TRFC       = 16,
    parameter int REF_PERIOD = 1560
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [25:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        emif_cke,
    output logic        emif_ce,
    output logic        emif_ras,
    output logic        emif_cas,
    output logic        emif_we,
    output logic        emif_dqm0,
    output logic        emif_dqm1,
    output logic [12:0] emif_addr,
    output logic [15:0] emif_dout,
    output logic        emif_doe,
    input  logic [15:0] emif_din
);
    typedef enum logic [3:0] {IDLE, ACT, TRCD_W, RD, RD_WAIT, WR, PRE, TRP_W, REF, TRFC_W} state_t;
    localparam logic [3:0] C_DESEL = 4'b1111;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_RD    = 4'b0101;
    localparam logic [3:0] C_WR    = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_REF   = 4'b0001;
    state_t      state, nxt;
    logic [15:0] tmr, dur;
    logic [3:0]  cmd;
    logic        done;
    logic [12:0] col_q;
    logic        we_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic        want_ref, pend_nxt;
    assign done = tmr == 16'd0;
`ifdef EMIF_MASTER_REFRESH_EN
    localparam int RW = $clog2(REF_PERIOD);
    logic [RW-1:0] ref_cnt;
    logic          ref_pend, ref_tick;
    assign ref_tick = ref_cnt == RW'(REF_PERIOD - 1);
    // an expiry seen in IDLE starts REF directly; otherwise it is held (saturating) until IDLE is reached
    assign want_ref = ref_pend | ref_tick;
    assign pend_nxt = want_ref & (state != IDLE);
    // free-running refresh interval counter and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt  <= ref_tick ? '0 : ref_cnt + 1'b1;
            ref_pend <= pend_nxt;
        end
    end
`else
    logic unused_ref_period;
    assign unused_ref_period = REF_PERIOD != 0;
    assign want_ref = 1'b0;
    assign pend_nxt = 1'b0;
`endif
    // next state, its hold time and the command it puts on the pins; refresh beats a host request in IDLE
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = want_ref ? REF : (req_valid && req_ready) ? ACT : IDLE;
            ACT:     nxt = done ? TRCD_W : ACT;
            TRCD_W:  nxt = done ? (we_q ? WR : RD) : TRCD_W;
            RD:      nxt = done ? RD_WAIT : RD;
            RD_WAIT: nxt = done ? PRE : RD_WAIT;
            WR:      nxt = done ? PRE : WR;
            PRE:     nxt = done ? TRP_W : PRE;
            TRP_W:   nxt = done ? IDLE : TRP_W;
            REF:     nxt = done ? TRFC_W : REF;
            TRFC_W:  nxt = done ? IDLE : TRFC_W;
            default: nxt = IDLE;
        endcase
        dur = (nxt == TRCD_W)  ? 16'(TRCD - 1) :
              (nxt == RD_WAIT) ? 16'(RD_LAT - CMD_CYC) :
              (nxt == TRP_W)   ? 16'(TRP - 1) :
              (nxt == TRFC_W)  ? 16'(TRFC - 1) :
              (nxt == IDLE)    ? 16'd0 : 16'(CMD_CYC - 1);
        cmd = (nxt == IDLE) ? C_DESEL :
              (nxt == ACT)  ? C_ACT :
              (nxt == RD)   ? C_RD :
              (nxt == WR)   ? C_WR :
              (nxt == PRE)  ? C_PRE :
              (nxt == REF)  ? C_REF : C_NOP;
    end
    // state, dwell timer, latched request and every registered pin/response output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= 16'd0;
            col_q     <= 13'd0;
            we_q      <= 1'b0;
            wdata_q   <= 16'd0;
            be_q      <= 2'b00;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
            emif_cke  <= 1'b0;
            {emif_ce, emif_ras, emif_cas, emif_we} <= C_DESEL;
            {emif_dqm1, emif_dqm0} <= 2'b11;
            emif_addr <= 13'd0;
            emif_dout <= 16'd0;
            emif_doe  <= 1'b0;
        end else begin
            state     <= nxt;
            tmr       <= (nxt != state) ? dur : done ? tmr : tmr - 16'd1;
            emif_cke  <= 1'b1;
            req_ready <= nxt == IDLE && emif_cke && !pend_nxt;
            if (state == IDLE && nxt == ACT) begin
                col_q   <= req_addr[12:0];
                we_q    <= req_we;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            {emif_ce, emif_ras, emif_cas, emif_we} <= cmd;
            {emif_dqm1, emif_dqm0} <= (nxt == RD || nxt == WR) ? ~be_q : 2'b11;
            emif_addr <= (state == IDLE && nxt == ACT) ? req_addr[25:13] :
                         (nxt == RD || nxt == WR)      ? col_q :
                         (nxt == PRE)                  ? 13'h0400 : emif_addr;
            emif_doe  <= nxt == WR;
            emif_dout <= (nxt == WR) ? wdata_q : emif_dout;
            rsp_valid <= state == RD_WAIT && done;
            rsp_rdata <= (state == RD_WAIT && done) ? emif_din : rsp_rdata;
        end
    end
endmodule

// File: tb/tb_emif_master.sv
// tb_emif_master: directed checks of emif_master command timing, read/write data, back-to-back, reset and refresh.
module tb_emif_master;
    localparam logic [3:0] DESEL = 4'b1111;
    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [3:0] ACTV  = 4'b0011;
    localparam logic [3:0] READ  = 4'b0101;
    localparam logic [3:0] WRITE = 4'b0100;
    localparam logic [3:0] PRECH = 4'b0010;
    localparam logic [3:0] REFR  = 4'b0001;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [25:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        emif_cke, emif_ce, emif_ras, emif_cas, emif_we, emif_dqm0, emif_dqm1, emif_doe;
    logic [12:0] emif_addr;
    logic [15:0] emif_dout;
    logic [15:0] emif_din = 16'hDEAD;
    logic [3:0]  cmd;
    logic [1:0]  dqm;
    int          checks = 0;
    int          passed = 0;
    assign cmd = {emif_ce, emif_ras, emif_cas, emif_we};
    assign dqm = {emif_dqm1, emif_dqm0};
    emif_master #(.REF_PERIOD(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .emif_cke(emif_cke), .emif_ce(emif_ce), .emif_ras(emif_ras), .emif_cas(emif_cas), .emif_we(emif_we),
        .emif_dqm0(emif_dqm0), .emif_dqm1(emif_dqm1), .emif_addr(emif_addr),
        .emif_dout(emif_dout), .emif_doe(emif_doe), .emif_din(emif_din)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; emif_din = 16'hDEAD;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    function automatic logic [3:0] wr_cmd(int k);
        return k <= 4 ? ACTV : k <= 8 ? NOP : k <= 12 ? WRITE : k <= 16 ? PRECH : k <= 20 ? NOP : DESEL;
    endfunction
    function automatic logic [3:0] rd_cmd(int k);
        return k <= 4 ? ACTV : k <= 8 ? NOP : k <= 12 ? READ : k <= 17 ? NOP : k <= 21 ? PRECH : k <= 25 ? NOP : DESEL;
    endfunction
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, emif_cke, emif_doe, cmd, dqm} !== 10'b0000_1111_11)
            $display("FAIL reset_ctrl: got %b expected %b", {req_ready, rsp_valid, emif_cke, emif_doe, cmd, dqm}, 10'b0000_1111_11);
        else passed++;
        checks++;
        if ({emif_addr, emif_dout, rsp_rdata} !== 45'd0)
            $display("FAIL reset_data: got %h expected 0", {emif_addr, emif_dout, rsp_rdata});
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({emif_cke, req_ready} !== 2'b10) $display("FAIL reset_clk1: got %b expected 10", {emif_cke, req_ready});
        else passed++;
        tick();
        checks++;
        if ({emif_cke, req_ready} !== 2'b11) $display("FAIL reset_clk2: got %b expected 11", {emif_cke, req_ready});
        else passed++;
    endtask
    task automatic test_write();
        logic [7:0] exp;
        do_reset();
        tick(); tick();
        req_we = 1'b1; req_addr = 26'h0012345; req_wdata = 16'hA55A; req_be = 2'b11; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            exp = {wr_cmd(c), (c >= 9 && c <= 12) ? 2'b00 : 2'b11, c >= 9 && c <= 12, c == 21};
            checks++;
            if ({cmd, dqm, emif_doe, req_ready} !== exp)
                $display("FAIL write_pins c=%0d: got %b expected %b", c, {cmd, dqm, emif_doe, req_ready}, exp);
            else passed++;
            if (c <= 8) begin
                checks++;
                if (emif_addr !== 13'h0009) $display("FAIL write_row c=%0d: got %h expected 0009", c, emif_addr);
                else passed++;
            end else if (c <= 12) begin
                checks++;
                if ({emif_addr, emif_dout} !== {13'h0345, 16'hA55A})
                    $display("FAIL write_col c=%0d: got %h/%h expected 0345/a55a", c, emif_addr, emif_dout);
                else passed++;
            end else if (c <= 20) begin
                checks++;
                if (emif_addr[10] !== 1'b1) $display("FAIL write_pre_a10 c=%0d: got %b expected 1", c, emif_addr[10]);
                else passed++;
            end
            if (c < 21) tick();
        end
    endtask
    task automatic read_seq();
        logic [9:0] exp;
        tick(); tick();
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL read_idle: got %b expected 10", {req_ready, rsp_valid});
        else passed++;
        req_we = 1'b0; req_addr = 26'h1A2B3C4; req_be = 2'b01; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            emif_din = (c == 17) ? 16'h1234 : 16'hDEAD;
            exp = {rd_cmd(c), (c >= 9 && c <= 12) ? 2'b10 : 2'b11, 1'b0, c == 26, c == 18, 1'b0};
            checks++;
            if ({cmd, dqm, emif_doe, req_ready, rsp_valid, 1'b0} !== exp)
                $display("FAIL read_pins c=%0d: got %b expected %b", c, {cmd, dqm, emif_doe, req_ready, rsp_valid, 1'b0}, exp);
            else passed++;
            if (c <= 8) begin
                checks++;
                if (emif_addr !== 13'h0D15) $display("FAIL read_row c=%0d: got %h expected 0d15", c, emif_addr);
                else passed++;
            end else if (c <= 12) begin
                checks++;
                if (emif_addr !== 13'h13C4) $display("FAIL read_col c=%0d: got %h expected 13c4", c, emif_addr);
                else passed++;
            end else if (c == 18) begin
                checks++;
                if (rsp_rdata !== 16'h1234) $display("FAIL read_data: got %h expected 1234", rsp_rdata);
                else passed++;
                checks++;
                if (emif_addr[10] !== 1'b1) $display("FAIL read_pre_a10: got %b expected 1", emif_addr[10]);
                else passed++;
            end
            if (c < 26) tick();
        end
        emif_din = 16'hDEAD;
    endtask
    task automatic test_read();
        do_reset();
        read_seq();
    endtask
    task automatic test_back_to_back();
        logic [4:0] exp;
        do_reset();
        tick(); tick();
        req_we = 1'b1; req_addr = 26'h0012345; req_wdata = 16'hA55A; req_be = 2'b11; req_valid = 1'b1;
        tick();
        for (int c = 1; c <= 42; c++) begin
            if (c == 1) req_wdata = 16'h5AA5;
            if (c == 22) req_valid = 1'b0;
            exp = {c <= 21 ? wr_cmd(c) : wr_cmd(c - 21), c == 21 || c == 42};
            checks++;
            if ({cmd, req_ready} !== exp)
                $display("FAIL b2b_pins c=%0d: got %b expected %b", c, {cmd, req_ready}, exp);
            else passed++;
            if ((c >= 9 && c <= 12) || (c >= 30 && c <= 33)) begin
                checks++;
                if (emif_dout !== (c <= 12 ? 16'hA55A : 16'h5AA5))
                    $display("FAIL b2b_dout c=%0d: got %h expected %h", c, emif_dout, c <= 12 ? 16'hA55A : 16'h5AA5);
                else passed++;
            end
            if (c < 42) tick();
        end
    endtask
    task automatic test_reset_mid_read();
        int stray;
        stray = 0;
        do_reset();
        tick(); tick();
        req_we = 1'b0; req_addr = 26'h1A2B3C4; req_be = 2'b01; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        checks++;
        if (cmd !== READ) $display("FAIL midrd_phase: got %b expected %b", cmd, READ);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd, dqm, emif_doe, emif_cke, req_ready} !== {DESEL, 2'b11, 3'b000})
            $display("FAIL midrd_async: got %b expected %b", {cmd, dqm, emif_doe, emif_cke, req_ready}, {DESEL, 2'b11, 3'b000});
        else passed++;
        emif_din = 16'h1234;
        repeat (10) begin
            tick();
            if (rsp_valid !== 1'b0) stray++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (rsp_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) $display("FAIL midrd_no_rsp: got %0d strobes expected 0", stray);
        else passed++;
        do_reset();
        read_seq();
    endtask
`ifdef EMIF_MASTER_REFRESH_EN
    task automatic test_refresh();
        logic [3:0] exp;
        do_reset();
        for (int e = 1; e <= 131; e++) begin
            tick();
            if (e == 63) begin
                req_we = 1'b1; req_addr = 26'h0012345; req_wdata = 16'hA55A; req_be = 2'b11; req_valid = 1'b1;
            end
            if (e == 85) req_valid = 1'b0;
            exp = e < 64 ? DESEL : e < 68 ? REFR : e < 84 ? NOP : e == 84 ? DESEL : e < 89 ? ACTV :
                  e < 93 ? NOP : e < 97 ? WRITE : e < 101 ? PRECH : e < 105 ? NOP : e < 128 ? DESEL : REFR;
            if (e >= 60) begin
                checks++;
                if (cmd !== exp) $display("FAIL refresh_cmd e=%0d: got %b expected %b", e, cmd, exp);
                else passed++;
            end
            if (e == 64 || e == 84) begin
                checks++;
                if (req_ready !== (e == 84)) $display("FAIL refresh_ready e=%0d: got %b expected %b", e, req_ready, e == 84);
                else passed++;
            end
        end
    endtask
`else
    task automatic test_idle_no_refresh();
        int n_ref, n_busy;
        n_ref = 0;
        n_busy = 0;
        do_reset();
        tick(); tick();
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (cmd === REFR) n_ref++;
            if (req_ready !== 1'b1) n_busy++;
        end
        checks++;
        if (n_ref !== 0) $display("FAIL idle_refresh: got %0d refresh cycles expected 0", n_ref);
        else passed++;
        checks++;
        if (n_busy !== 0) $display("FAIL idle_ready: got %0d not-ready cycles expected 0", n_busy);
        else passed++;
    endtask
`endif
    initial begin
        #2;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_read();
`ifdef EMIF_MASTER_REFRESH_EN
        test_refresh();
`else
        test_idle_no_refresh();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
